// File: rtl/activate_pipe.sv
// activate_pipe: 2-stage valid/ready activation unit (identity/ReLU/leaky/clamp).
// Optional output-transfer clip counter enabled by ACTIVATE_PIPE_STATS_EN.
module activate_pipe #(
    parameter int DATA_W     = 17,
    parameter int FRAC_W     = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 1536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [1:0]        in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
`ifdef ACTIVATE_PIPE_STATS_EN
    ,
    output logic        [31:0]       clip_count
`endif
);

    localparam logic signed [DATA_W-1:0] CMAX = DATA_W'(CLAMP_MAX);

    // Reject parameter sets that would break the no-overflow guarantee.
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > DATA_W - 1 || CLAMP_MAX <= 0 ||
        CLAMP_MAX >= (2 ** (DATA_W - 1)) || FRAC_W < 0) begin : g_bad_params
        $error("activate_pipe: illegal parameter set");
    end

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_data;
    logic        [1:0]        s1_mode;
    logic                     s2_valid;
    logic signed [DATA_W-1:0] s2_data;
    logic signed [DATA_W-1:0] act;
    logic                     adv1;
    logic                     adv2;

    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;

    // Activation of the stage-1 sample according to its own mode.
    always_comb begin
        act = s1_data;
        unique case (s1_mode)
            2'd0: act = s1_data;
            2'd1: begin
                if (s1_data < 0) act = '0;
            end
            2'd2: begin
                if (s1_data < 0) act = s1_data >>> LEAK_SHIFT;
            end
            2'd3: begin
                if (s1_data < 0)
                    act = '0;
                else if (s1_data > CMAX)
                    act = CMAX;
            end
            default: act = s1_data;
        endcase
    end

    // Stage 1: capture the raw sample and its mode on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    // Stage 2: hold the activated result until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= act;
        end
    end

`ifdef ACTIVATE_PIPE_STATS_EN
    logic s2_clip;

    // Remember whether the stage-2 result differs from its input.
    always_ff @(posedge clk) begin
        if (rst)
            s2_clip <= 1'b0;
        else if (adv2 && s1_valid)
            s2_clip <= (act != s1_data);
    end

    // Count altered samples once per output transfer, saturating.
    always_ff @(posedge clk) begin
        if (rst)
            clip_count <= '0;
        else if (s2_valid && out_ready && s2_clip && clip_count != '1)
            clip_count <= clip_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_activate_pipe.sv
// Bench for activate_pipe: directed cases plus a randomized stream against
// a queue-based reference model of the activation rules.
module tb_activate_pipe;

    localparam int DATA_W     = 17;
    localparam int LEAK_SHIFT = 3;
    localparam int CLAMP_MAX  = 1536;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic        [1:0]        in_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
`ifdef ACTIVATE_PIPE_STATS_EN
    logic        [31:0]       clip_count;
`endif

    activate_pipe #(
        .DATA_W(DATA_W), .FRAC_W(8), .LEAK_SHIFT(LEAK_SHIFT), .CLAMP_MAX(CLAMP_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
`ifdef ACTIVATE_PIPE_STATS_EN
        , .clip_count(clip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        int cyc;
        bit clip;
    } item_t;

    item_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    exp_clip    = 0;
    bit    lat_chk     = 0;
    bit    last_acc    = 0;
    bit    hold_pend   = 0;
    int    held        = 0;

    function automatic int model(int x, int m);
        int d, f;
        case (m)
            0: return x;
            1: return (x < 0) ? 0 : x;
            2: begin
                if (x >= 0) return x;
                d = 1 << LEAK_SHIFT;
                f = x / d;
                if (f * d != x) f = f - 1;
                return f;
            end
            default: return (x < 0) ? 0 : ((x > CLAMP_MAX) ? CLAMP_MAX : x);
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1ns later, model the edge.
    task automatic step(input bit v, input int d, input int m, input bit ordy);
        item_t it;
        int    y;
        in_valid  = v;
        in_data   = DATA_W'(d);
        in_mode   = 2'(m);
        out_ready = ordy;
        #1;
        last_acc = 0;
        if (!rst) begin
            if (hold_pend) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", $signed(out_data), held);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", $signed(out_data), 32'sh7fffffff);
                end else begin
                    it = q.pop_front();
                    chk("data", $signed(out_data), it.y);
                    if (lat_chk) chk("latency", cyc - it.cyc, 2);
                    if (it.clip) exp_clip++;
                end
            end
            if (in_valid && in_ready) begin
                y = model(d, m);
                q.push_back('{y, cyc, (y != d)});
                last_acc = 1;
            end
            hold_pend = out_valid && !out_ready;
            held      = $signed(out_data);
        end else begin
            hold_pend = 0;
        end
        @(negedge clk);
        cyc++;
        if (rst) begin
            q.delete();
            exp_clip = 0;
        end
    endtask

    task automatic send(input int d, input int m, input bit ordy);
        int n = 0;
        do begin
            step(1, d, m, ordy);
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            step(0, 0, 0, 1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    int s1v[5] = '{0, 12345, -1, -32768, 32767};
    int s2v[4] = '{-17, -1, -65536, 100};
    int s3v[5] = '{1535, 1536, 1537, 30000, -4};
    int bpv[4] = '{-300, 77, -2, 1600};

    initial begin
        int acc, n;
        logic signed [DATA_W-1:0] r;
        rst = 1; in_valid = 0; in_data = '0; in_mode = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        lat_chk = 1;
        foreach (s1v[i]) send(s1v[i], 1, 1);
        drain();
        foreach (s2v[i]) send(s2v[i], 2, 1);
        send(-5, 0, 1);
        drain();
        foreach (s3v[i]) send(s3v[i], 3, 1);
        send(-65536, 2, 1);
        send(-9, 1, 1);
        send(65535, 3, 1);
        drain();
        lat_chk = 0;

        send(bpv[0], 2, 0);
        send(bpv[1], 3, 0);
        repeat (3) begin
            step(1, bpv[2], 0, 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_no_accept", 32'(last_acc), 0);
        end
        send(bpv[2], 0, 1);
        send(bpv[3], 3, 1);
        drain();

        send(-40, 2, 0);
        send(900, 1, 0);
        rst = 1;
        step(0, 0, 0, 0);
        rst = 0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", $signed(out_data), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        repeat (4) step(0, 0, 0, 1);

`ifdef ACTIVATE_PIPE_STATS_EN
        rst = 1;
        step(0, 0, 0, 0);
        rst = 0;
        step(1, -1, 1, 1);
        step(1, -8, 2, 1);
        step(1, 2000, 3, 1);
        step(1, -9, 0, 0);
        step(1, -9, 0, 0);
        step(1, -9, 0, 0);
        #1;
        chk("clip_stall", $signed(clip_count), 1);
        send(-9, 0, 1);
        drain();
        #1;
        chk("clip_model", $signed(clip_count), exp_clip);
        chk("clip_final", $signed(clip_count), 3);
`endif

        acc = 0;
        n = 0;
        while (acc < 1000 && n < 20000) begin
            r = DATA_W'($urandom);
            step(($urandom % 4) != 0, int'(r), int'($urandom % 4),
                 ($urandom % 10) < 7);
            if (last_acc) acc++;
            n++;
        end
        chk("random_accepts", acc, 1000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/activate_pipe.md
Name: activate_pipe

Overview:
- Parametrised, multi-mode activation unit; the successor to the single-cycle ReLU stage.
- Sits between the neuron accumulator and the next layer's input.
- Applies identity, ReLU, leaky ReLU or clamped ReLU to signed fixed-point samples through a 2-stage valid/ready pipeline with full throughput and backpressure.
- Mode is selected per sample and travels with the data.

Parameters:
- DATA_W, 17, sample width (signed two's complement).
- FRAC_W, 8, fractional bits; informational only, no datapath effect.
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT; legal range 1..DATA_W-1.
- CLAMP_MAX, 1536, upper bound for clamp mode (6.0 at FRAC_W=8); must satisfy 0 < CLAMP_MAX < 2^(DATA_W-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit can accept a sample this cycle.
- in_data  in  DATA_W  signed input sample.
- in_mode  in  2  0=identity, 1=ReLU, 2=leaky ReLU, 3=clamp ReLU.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  DATA_W  signed activated sample.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0. in_ready reads 1 in the first cycle after reset deasserts. Reset mid-operation discards every in-flight sample; nothing appears after reset.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage 1 registers the raw sample plus mode.
- Stage 2 registers the activated result; out_data/out_valid come directly from the stage-2 registers.
- Stall rules:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is a combinational path from out_ready to in_ready; it is permitted.
- Latency: an input accepted at edge N is presented on out_data after edge N+2 when there is no backpressure. Throughput is 1 sample/cycle.
- Data integrity: under backpressure, out_data and out_valid hold stable until transferred. No sample is dropped or duplicated. Order is preserved. Up to 2 samples are buffered.
- Arithmetic (x = sample, all signed):
  - mode 0: y = x.
  - mode 1: y = (x<0) ? 0 : x.
  - mode 2: y = (x<0) ? (x >>> LEAK_SHIFT) : x. The arithmetic shift floors toward -inf, so -17 >>> 3 = -3 and -1 >>> 3 = -1.
  - mode 3: y = (x<0) ? 0 : (x > CLAMP_MAX ? CLAMP_MAX : x).
- Boundaries:
  - No overflow is possible in any mode; the output width equals the input width.
  - Most negative input (-2^(DATA_W-1)) in mode 2 gives -2^(DATA_W-1-LEAK_SHIFT).
  - x == CLAMP_MAX passes unchanged in mode 3.
- Simultaneous accept and emit with both stages full: both stages advance in the same cycle; no bubble.
- in_mode is sampled only on an input transfer. Mode changes between samples are allowed every cycle.

Optional Feature:
- Macro: ACTIVATE_PIPE_STATS_EN.
- When defined:
  - Adds output port clip_count (out, 32): the number of output transfers whose y != x, i.e. zeroed, leaked or clamped.
  - Increments once per output transfer, not per stall cycle.
  - Saturates at 2^32-1.
  - Clears to 0 on rst.
- When undefined: no port and no counter logic. Datapath behaviour is identical in both cases.

Test Plan:
- Defaults, out_ready=1, stream modes 1/1/1/1/1 with in_data 0, 12345, -1, -32768, 32767 -> out_data 0, 12345, 0, 0, 32767, each appearing 2 cycles after accept, one per cycle.
- Mode 2 with in_data -17, -1, -65536, 100 -> -3, -1, -8192, 100. Mode 0 with -5 -> -5.
- Mode 3 with in_data 1535, 1536, 1537, 30000, -4 -> 1535, 1536, 1536, 1536, 0.
- Backpressure:
  - Stimulus: hold out_ready=0 while offering 4 samples.
  - Required: in_ready falls after 2 accepts, out_data is stable while stalled, and releasing out_ready yields all samples in order with no loss or duplicate.
  - Randomized version: random in_valid/out_ready for 1000 samples, checked against a scoreboard.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle with both stages full.
  - Required: out_valid=0 and out_data=0 the next cycle, no stale sample ever emitted, and in_ready=1 after rst deasserts.
- ACTIVATE_PIPE_STATS_EN defined:
  - Stimulus: modes 1, 2, 3, 0 with inputs -1, -8, 2000, -9, with a 3-cycle stall on the second output.
  - Required: clip_count=3; the stall does not add increments.
